data_mem_lsu: RTL

Parametrised RV32 data memory with an integrated load/store unit. It replaces the flat word-only memory in the single-cycle datapath's load/store path and sits between the execute stage and the storage array. It supports byte, halfword and word accesses with sign/zero extension and per-byte write lanes. Requests and responses use valid/ready handshakes, with alignment and range error reporting. After reset, a clear state machine zeroes the array one word per cycle, because the array itself is not asynchronously reset.

---
 rtl/data_mem_lsu.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_lsu.sv
// data_mem_lsu
//   RV32 data memory with an integrated load/store unit. Byte, halfword and
//   word accesses with sign/zero extension and per-byte write lanes, behind
//   valid/ready request and response handshakes. A single registered response
//   slot gives 1-cycle load latency with back-to-back throughput.
//
//   The storage array has no reset of its own. After reset an optional clear
//   sweep writes zero to one word per cycle before requests are accepted.
module data_mem_lsu #(
  parameter int    WORDS          = 64,
  parameter int    ADDR_W         = 32,
  parameter string MEM_INIT       = "",
  parameter bit    CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  // Width of an array index and of the full word-address field of a request.
  localparam int IDX_W  = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int WIDX_W = ADDR_W - 2;

  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(WORDS - 1);
  localparam logic [WIDX_W-1:0] WORDS_LIM = WIDX_W'(WORDS);

  // RV32 load/store width encodings.
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_CLEAR,
    ST_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [IDX_W-1:0] clr_ptr;
  logic [31:0]      mem [WORDS];

  // Request decode.
  logic [WIDX_W-1:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic [1:0]        lane;
  logic              in_range;
  logic              f3_legal;
  logic              store_bad;
  logic              misaligned;
  logic              req_err;
  logic [3:0]        byte_en;
  logic [31:0]       wr_data;
  logic [31:0]       rd_word;
  logic [7:0]        rd_byte;
  logic [15:0]       rd_half;
  logic [31:0]       load_data;
  logic              accept;
  logic              do_write;

  // Address fields. Upper address bits are kept whole so that an address past
  // the end of the array is reported as an error instead of wrapping.
  assign word_idx = req_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign lane     = req_addr[1:0];
  assign in_range = (word_idx < WORDS_LIM);

  assign accept   = req_valid && req_ready;
  assign do_write = accept && req_we && !req_err;

  // Width decode: legality, alignment, store lane enables and the error flag.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the case can leave it unassigned and infer a latch.
  always_comb begin
    f3_legal   = 1'b0;
    store_bad  = 1'b0;
    misaligned = 1'b0;
    byte_en    = 4'b0000;
    unique case (req_funct3)
      F3_B: begin
        f3_legal = 1'b1;
        byte_en  = 4'b0001 << lane;
      end
      F3_H: begin
        f3_legal   = 1'b1;
        misaligned = lane[0];
        byte_en    = lane[1] ? 4'b1100 : 4'b0011;
      end
      F3_W: begin
        f3_legal   = 1'b1;
        misaligned = |lane;
        byte_en    = 4'b1111;
      end
      F3_BU: begin
        f3_legal  = 1'b1;
        store_bad = req_we;
      end
      F3_HU: begin
        f3_legal   = 1'b1;
        misaligned = lane[0];
        store_bad  = req_we;
      end
      default: begin
        f3_legal = 1'b0;
      end
    endcase
    req_err = !f3_legal || store_bad || misaligned || !in_range;
  end

  // Store data replicated across lanes so each enabled lane picks its bits.
  always_comb begin
    unique case (req_funct3[1:0])
      2'b00:   wr_data = {4{req_wdata[7:0]}};
      2'b01:   wr_data = {2{req_wdata[15:0]}};
      default: wr_data = req_wdata;
    endcase
  end

  // Load path: select the addressed byte/halfword, right-justify and extend.
  always_comb begin
    rd_word   = in_range ? mem[mem_idx] : 32'h0;
    rd_byte   = rd_word[{lane, 3'b000} +: 8];
    rd_half   = lane[1] ? rd_word[31:16] : rd_word[15:0];
    load_data = 32'h0;
    if (!req_we && !req_err) begin
      unique case (req_funct3)
        F3_B:    load_data = {{24{rd_byte[7]}}, rd_byte};
        F3_BU:   load_data = {24'h0, rd_byte};
        F3_H:    load_data = {{16{rd_half[15]}}, rd_half};
        F3_HU:   load_data = {16'h0, rd_half};
        F3_W:    load_data = rd_word;
        default: load_data = 32'h0;
      endcase
    end
  end

  // Storage array: clear sweep writes one zero word per cycle, otherwise
  // accepted error-free stores update only their enabled byte lanes.
  // NOTE: the array has no reset term on purpose; a reset on every word would
  // stop it mapping onto RAM macros, so zeroing is done by the clear sweep.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem[clr_ptr] <= 32'h0;
    end else if (do_write) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) begin
          mem[mem_idx][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // State register; reset picks the sweep or goes straight to RUN.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples values from before the edge, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (CLEAR_ON_RESET) begin
        state_q <= ST_CLEAR;
      end else begin
        state_q <= ST_RUN;
      end
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      ST_CLEAR: begin
        busy = 1'b1;
        if (clr_ptr == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        req_ready = !rsp_valid || rsp_ready;
      end
    endcase
  end

  // Clear sweep pointer; restarts at word 0 on every reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clr_ptr <= '0;
    end else if (state_q == ST_CLEAR) begin
      if (clr_ptr == LAST_IDX) begin
        clr_ptr <= '0;
      end else begin
        clr_ptr <= clr_ptr + 1'b1;
      end
    end
  end

  // Single response slot: loaded on accept, held until consumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= load_data;
      rsp_err   <= req_err;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
